// File: rtl/sar_scan_scheduler.sv
// Round-robin scheduler time-sharing one SAR converter: grant, mux settle, convert, capture tagged result.
// Grant one edge after an IDLE request sample; sar_enable SETTLE_CYCLES later; no backpressure, requests are level-held.
module sar_scan_scheduler #(
    parameter int WIDTH          = 8,
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      sar_done,
    input  logic [WIDTH-1:0]          sar_result,
    output logic [$clog2(NUM_CH)-1:0] mux_sel,
    output logic                      sar_enable,
    output logic [NUM_CH-1:0]         grant,
    output logic                      busy,
    output logic [WIDTH-1:0]          result,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic                      result_valid,
    output logic                      timeout_err
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]        r_state;
    logic [CHW-1:0]    r_last_ch;
    logic [CHW-1:0]    r_mux_sel;
    logic [NUM_CH-1:0] r_grant;
    logic [SW-1:0]     r_settle_cnt;
    logic [TW-1:0]     r_to_cnt;
    logic              r_done_seen;
    logic [WIDTH-1:0]  r_result;
    logic [CHW-1:0]    r_result_ch;
    logic              r_result_valid;
    logic              r_timeout_err;

    logic              w_found;
    logic [CHW-1:0]    w_sel;
    logic [CHW-1:0]    w_cand;
    logic [NUM_CH-1:0] w_grant;

    // Search upward from the channel after the last one served, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = CHW'((int'(r_last_ch) + i) % NUM_CH);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
        w_grant        = '0;
        w_grant[w_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_ch      <= CHW'(NUM_CH - 1);
            r_mux_sel      <= '0;
            r_grant        <= '0;
            r_settle_cnt   <= '0;
            r_to_cnt       <= '0;
            r_done_seen    <= 1'b0;
            r_result       <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable && w_found) begin
                        r_grant      <= w_grant;
                        r_mux_sel    <= w_sel;
                        r_settle_cnt <= '0;
                        r_state      <= SETTLE;
                    end else begin
                        r_grant <= '0;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        r_to_cnt    <= '0;
                        r_done_seen <= 1'b0;
                        r_state     <= CONVERT;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    // Abort wins over capture and timeout; the result is taken on the falling edge of done.
                    if (!enable) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else if (r_done_seen && !sar_done) begin
                        r_result       <= sar_result;
                        r_result_ch    <= r_mux_sel;
                        r_result_valid <= 1'b1;
                        r_state        <= CAPTURE;
                    end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_last_ch     <= r_mux_sel;
                        r_grant       <= '0;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (sar_done) begin
                            r_done_seen <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (enable) begin
                        r_last_ch <= r_mux_sel;
                    end
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mux_sel      = r_mux_sel;
    assign sar_enable   = (r_state == CONVERT);
    assign grant        = r_grant;
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = r_result_valid;
    assign timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_sar_scan_scheduler.sv
// Bench for sar_scan_scheduler: directed scenarios, a cycle-level reference model and a behavioural SAR.
module tb_sar_scan_scheduler;
    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 50;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic         sar_done = 1'b0;
    logic [W-1:0] sar_result = 8'h3C;
    logic [1:0]   mux_sel;
    logic         sar_enable;
    logic [N-1:0] grant;
    logic         busy;
    logic [W-1:0] result;
    logic [1:0]   result_ch;
    logic         result_valid;
    logic         timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    int sar_cnt = 0;
    bit sar_mode = 1'b1;
    bit drop_on_fall = 1'b0;

    // Reference model: service phase tracked by age since grant.
    bit         m_svc, m_cap, m_seen, m_to;
    int         m_age, m_ch, m_last, m_mux, m_res_ch;
    logic [7:0] m_res;

    always #5 clk = ~clk;

    sar_scan_scheduler #(
        .WIDTH(W), .NUM_CH(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req),
        .sar_done(sar_done), .sar_result(sar_result),
        .mux_sel(mux_sel), .sar_enable(sar_enable), .grant(grant), .busy(busy),
        .result(result), .result_ch(result_ch), .result_valid(result_valid),
        .timeout_err(timeout_err)
    );

    function automatic logic [19:0] act_vec();
        return {grant, mux_sel, sar_enable, busy, result, result_ch, result_valid, timeout_err};
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [3:0] g;
        logic       conv;
        logic       bsy;
        g    = (m_svc || m_cap) ? (4'b0001 << m_ch) : 4'b0000;
        conv = m_svc && (m_age >= S);
        bsy  = m_svc || m_cap;
        return {g, 2'(m_mux), conv, bsy, m_res, 2'(m_res_ch), m_cap, m_to};
    endfunction

    task automatic model_reset();
        m_svc = 1'b0; m_cap = 1'b0; m_seen = 1'b0; m_to = 1'b0;
        m_age = 0; m_ch = 0; m_last = N - 1; m_mux = 0; m_res_ch = 0; m_res = '0;
    endtask

    task automatic model_step();
        int  c;
        bit  found;
        m_to = 1'b0;
        if (m_cap) begin
            m_cap = 1'b0;
            if (enable) m_last = m_ch;
        end else if (m_svc) begin
            if (!enable) begin
                m_svc = 1'b0;
            end else if (m_age < S) begin
                m_age++;
                if (m_age == S) m_seen = 1'b0;
            end else if (m_seen && !sar_done) begin
                m_res = sar_result; m_res_ch = m_ch; m_svc = 1'b0; m_cap = 1'b1;
            end else if (m_age - S == T - 1) begin
                m_to = 1'b1; m_svc = 1'b0; m_last = m_ch;
            end else begin
                if (sar_done) m_seen = 1'b1;
                m_age++;
            end
        end else if (enable && req != 4'b0000) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && ((req >> c) & 4'b0001) != 4'b0000) begin
                    found = 1'b1;
                    m_ch = c;
                end
            end
            m_mux = m_ch; m_svc = 1'b1; m_age = 0;
        end
    endtask

    // Behavioural SAR: done high for enabled cycles 2..4, output updates as done falls.
    task automatic sar_drive();
        if (sar_enable === 1'b1) sar_cnt++; else sar_cnt = 0;
        sar_done = 1'b0;
        if (sar_cnt == 0) begin
            sar_result = 8'h3C;
        end else if (sar_mode && sar_cnt >= 2 && sar_cnt <= 4) begin
            sar_done = 1'b1;
        end else if (sar_mode && sar_cnt == 5) begin
            sar_result = {6'b101001, mux_sel};
            if (drop_on_fall) begin
                enable = 1'b0;
                drop_on_fall = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        sar_drive();
        #2;
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act_vec(), exp_vec());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rv(input string nm, input int budget);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(result_valid), 32'h1);
    endtask

    task automatic serve(input logic [3:0] r);
        req = r;
        tick();
        req = '0;
        wait_rv("serve_rv", 40);
        tick();
    endtask

    int         rr_ch [5] = '{0, 1, 2, 3, 0};
    logic [3:0] rr_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_res[5] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA4};

    initial begin
        int n, en_hi, to_n, rv_n;
        model_reset();
        #1 reset = 1'b1;
        #2 chk("reset_outputs", 32'(act_vec()), 32'h0);
        tick();
        tick();
        reset = 1'b0; enable = 1'b1; req = 4'b0001;
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_mux", 32'(mux_sel), 32'h0);
        req = '0;
        wait_rv("first_rv", 40);
        chk("first_result", 32'(result), 32'hA4);
        tick();

        // Single request on ch1, req dropped during settle.
        req = 4'b0010;
        tick();
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_mux", 32'(mux_sel), 32'h1);
        req = '0;
        n = 0;
        while (sar_enable !== 1'b1 && n < 20) begin tick(); n++; end
        chk("settle_len", 32'(n), 32'd4);
        wait_rv("single_rv", 40);
        chk("single_result", 32'(result), 32'hA5);
        chk("single_result_ch", 32'(result_ch), 32'h1);
        tick();
        chk("single_rv_pulse", 32'(result_valid), 32'h0);

        // Async reset between edges while busy.
        req = 4'b1111;
        tick();
        tick();
        #2 reset = 1'b1;
        model_reset();
        #1 chk("async_reset", 32'(act_vec()), 32'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_rv("rr_rv", 40);
            chk("rr_grant", 32'(grant), 32'(rr_gnt[i]));
            chk("rr_result_ch", 32'(result_ch), 32'(rr_ch[i]));
            chk("rr_result", 32'(result), 32'(rr_res[i]));
            if (i == 4) req = '0;
            tick();
        end
        serve(4'b1000);

        // Timeout on ch0, then ch2 is next.
        sar_mode = 1'b0;
        req = 4'b0101;
        tick();
        chk("to_grant", 32'(grant), 32'h1);
        n = 0; en_hi = 0; to_n = 0; rv_n = 0;
        while (grant !== 4'b0100 && n < 200) begin
            tick();
            n++;
            en_hi += int'(sar_enable);
            to_n  += int'(timeout_err);
            rv_n  += int'(result_valid);
            if (timeout_err === 1'b1) begin
                chk("to_result_held", 32'(result), 32'hA7);
                sar_mode = 1'b1;
            end
        end
        chk("to_next_grant", 32'(grant), 32'h4);
        chk("to_enable_cycles", 32'(en_hi), 32'd50);
        chk("to_pulses", 32'(to_n), 32'd1);
        chk("to_no_rv", 32'(rv_n), 32'd0);
        req = '0;
        wait_rv("to_next_rv", 40);
        chk("to_next_result", 32'(result), 32'hA6);
        tick();

        // Enable abort 10 cycles into convert on ch2.
        serve(4'b0010);
        sar_mode = 1'b0;
        req = 4'b0100;
        tick();
        chk("abort_grant", 32'(grant), 32'h4);
        req = '0;
        n = 0;
        while (sar_enable !== 1'b1 && n < 20) begin tick(); n++; end
        repeat (9) tick();
        enable = 1'b0;
        tick();
        chk("abort_sar_enable", 32'(sar_enable), 32'h0);
        chk("abort_grant_clr", 32'(grant), 32'h0);
        rv_n = 0;
        repeat (5) begin
            tick();
            rv_n += int'(result_valid) + int'(timeout_err);
        end
        chk("abort_no_pulse", 32'(rv_n), 32'd0);
        enable = 1'b1; req = 4'b1111; sar_mode = 1'b1;
        tick();
        chk("abort_regrant", 32'(grant), 32'h4);
        req = '0;
        wait_rv("abort_rv", 40);
        chk("abort_result_ch", 32'(result_ch), 32'h2);
        tick();

        // Enable drops on the cycle sar_done falls.
        drop_on_fall = 1'b1;
        req = 4'b1000;
        tick();
        req = '0;
        rv_n = 0;
        repeat (20) begin
            tick();
            rv_n += int'(result_valid);
        end
        chk("drop_no_rv", 32'(rv_n), 32'd0);
        chk("drop_result_held", 32'(result), 32'hA6);
        chk("drop_busy", 32'(busy), 32'h0);
        enable = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sar_scan_scheduler.md
Name: sar_scan_scheduler

Overview:
- Multi-channel scan controller that time-shares the single successive-approximation converter (comparator plus DAC) between NUM_CH analog input requesters.
- Arbitrates requests round-robin, drives the analog mux select, and waits a settle interval.
- Sequences the converter's enable, then captures its digitized output and tags it with the channel number.
- Sits between the per-channel request sources (display/sampling logic) and the SAR FSM.

Parameters:
- WIDTH, 8, converter result width.
- NUM_CH, 4, number of requesting channels (2..16).
- SETTLE_CYCLES, 5000, clk cycles of mux settle with sar_enable low; must be ≥ the converter's internal tick period.
- TIMEOUT_CYCLES, 100000, maximum clk cycles sar_enable stays high waiting for a result.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global scan enable.
- req  in  NUM_CH  per-channel level request.
- sar_done  in  1  converter done (held high for a full converter tick).
- sar_result  in  WIDTH  converter digitized output.
- mux_sel  out  $clog2(NUM_CH)  analog mux channel select.
- sar_enable  out  1  converter enable.
- grant  out  NUM_CH  one-hot channel currently being serviced.
- busy  out  1  high whenever state != IDLE.
- result  out  WIDTH  last captured conversion.
- result_ch  out  $clog2(NUM_CH)  channel of result.
- result_valid  out  1  one-cycle pulse on new result.
- timeout_err  out  1  one-cycle pulse on conversion timeout.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - last_ch=NUM_CH-1, so channel 0 wins first.
  - All counters and done_seen cleared.
- States: IDLE, SETTLE, CONVERT, CAPTURE. All outputs are registered/Moore. sar_enable = (state==CONVERT).
- IDLE:
  - If enable && |req: select the first set req bit searching upward from (last_ch+1) mod NUM_CH with wrap.
  - Next edge: grant/mux_sel loaded, settle counter=0, state→SETTLE.
  - Otherwise stay in IDLE with grant=0.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then →CONVERT; clear timeout counter and done_seen.
  - sar_enable rises exactly SETTLE_CYCLES cycles after grant appears.
- CONVERT:
  - sar_enable=1. Set done_seen on the first cycle sar_done=1.
  - On the first cycle with done_seen && !sar_done (falling edge; converter output updates at end of its done phase): latch result<=sar_result, result_ch<=mux_sel, →CAPTURE.
  - sar_done high on CONVERT entry counts normally; SETTLE_CYCLES ≥ tick guarantees no stale done.
- Timeout:
  - If the capture condition has not occurred after TIMEOUT_CYCLES cycles in CONVERT, pulse timeout_err for 1 cycle.
  - Set last_ch=current, clear grant, →IDLE. No result_valid; result is unchanged.
- CAPTURE:
  - result_valid=1 for exactly one cycle; sar_enable=0.
  - last_ch=current; grant cleared; →IDLE.
- Request handling:
  - req is sampled only in IDLE. Deasserting the granted req mid-service does not abort; the conversion completes and is reported.
- enable deasserted in SETTLE/CONVERT/CAPTURE:
  - Next edge →IDLE; grant=0, sar_enable=0.
  - No result_valid or timeout_err. last_ch is unchanged, so the same channel is re-granted first.
  - Takes priority over a simultaneous capture or timeout.
- Other rules:
  - result/result_ch hold until the next capture.
  - Minimum gap between consecutive sar_enable high periods is 1 + SETTLE_CYCLES cycles.
  - Counters must be sized via $clog2 of their limits; no wrap is permitted before the terminal count.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=50, behavioural SAR model):
- **Async reset.** Assert reset between clk edges → all outputs 0 immediately; after release with req=0001, enable=1 → grant=0001, mux_sel=0.
- **Single request.** req=0010, enable=1; model holds sar_done high 3 cycles then low with sar_result=0xA5 → grant=0010 and mux_sel=1 one edge after IDLE sample; sar_enable rises 4 cycles later; single result_valid pulse with result=0xA5, result_ch=1.
- **Round-robin fairness.** req=1111 held, model always completes → grants in order 0001, 0010, 0100, 1000, 0001; result_ch sequence 0,1,2,3,0.
- **Timeout.** Model never asserts sar_done, req=0101 → sar_enable high exactly 50 cycles; one timeout_err pulse; no result_valid; next grant=0100.
- **Enable abort.** Drop enable 10 cycles into CONVERT on channel 2 → sar_enable=0 and grant=0 next edge, no pulses; re-enable with req=1111 → channel 2 re-granted first.
- **Simultaneous events.** Enable drops on the same cycle sar_done falls → no result_valid, result unchanged. Also: req deasserted during SETTLE → conversion still completes with result_valid.
